vx_wb_commit_arbiter: RTL
=========================

# vx_wb_commit_arbiter

Shares one issue slot's writeback port among `NUM_REQS` execute-unit commit streams, feeding the scoreboard's writeback interface. It round-robin arbitrates single-beat and multi-beat (sop..eop) writeback packets, locking the grant to one requester until that requester's eop beat is accepted. The scoreboard clears register in-use bits only on eop, so interleaved packets are not allowed. The output is registered and has no backpressure, because the scoreboard writeback port is always ready.

## Interface
- `NUM_REQS`, 4: number of requesting execute units (≥1).
- `DATAW`, 64: payload width (wis, rd, PC, tmask, data, uuid, packed by the caller).
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `req_valid` input NUM_REQS: per-requester beat valid.
- `req_data` input NUM_REQS×DATAW: per-requester payload.
- `req_sop` input NUM_REQS: first beat of packet.
- `req_eop` input NUM_REQS: last beat of packet.
- `req_ready` output NUM_REQS: beat accepted this cycle (one-hot or zero).
- `wb_valid` output 1: registered writeback beat valid.
- `wb_data` output DATAW: registered payload.
- `wb_sop` output 1: registered sop.
- `wb_eop` output 1: registered eop.
- `wb_idx` output CLOG2(NUM_REQS) (min 1): source requester of the beat.
- `proto_err` output 1: sticky protocol-violation flag.

## Operation
- State machine has two states.
  - IDLE: no lock held.
  - LOCKED: the grant is owned by the requester in `owner`.
- In IDLE, the grant goes to the first valid requester at or after `rr_ptr`, scanning cyclically.
  - If the granted beat has eop=1, stay in IDLE and set `rr_ptr` = winner+1 (mod NUM_REQS).
  - If the granted beat has eop=0, go to LOCKED with `owner` = winner.
- In LOCKED, only `owner` can be granted; other requesters see ready=0.
  - If the owner is not valid, no grant is made and wb_valid=0 the next cycle. This is a bubble, not an unlock.
  - When the owner's eop beat is granted, return to IDLE and set `rr_ptr` = owner+1.
- `req_ready[i]` = grant[i], and a grant requires `req_valid[i]`. There is no output backpressure, so every granted beat is transferred.
- Protocol errors set `proto_err`, which stays set until reset:
  - a beat granted in IDLE with sop=0;
  - a beat granted in LOCKED with sop=1.
- The beat is still forwarded when `proto_err` is set; arbitration is unaffected.
- `rr_ptr` wraps from NUM_REQS-1 to 0.
- With NUM_REQS=1 the FSM still operates, `rr_ptr` stays 0 and `wb_idx` is 0.

## Timing
- Latency is 1 cycle: a beat granted in cycle t appears on wb_* in cycle t+1.
- wb_valid=0 in any cycle following a cycle with no grant. wb_data, wb_sop, wb_eop and wb_idx hold their previous values when wb_valid=0.
- `req_ready` is combinational from `req_valid`, state and `rr_ptr`. There is no combinational path from wb_* to req_*.
- Throughput is one beat per cycle. Back-to-back packets from different requesters incur no bubble; an eop beat and the next requester's sop beat go out in consecutive cycles.
- Reset values:
  - outputs: wb_valid=0, wb_data=0, wb_sop=0, wb_eop=0, wb_idx=0, proto_err=0;
  - internal state: FSM=IDLE, rr_ptr=0, owner=0.
- Reset mid-packet drops the lock and any remaining beats. The first post-reset grant follows IDLE rules from rr_ptr=0.
- When requests arrive simultaneously in IDLE, the only tie-break is `rr_ptr`; there is no fixed priority.

## Structure
- Add to VX_gpu_pkg:
  - the IDLE/LOCKED state enum;
  - a `wb_beat_t` struct for {data, sop, eop}, so the arbiter and writeback packers share one layout.
- Sub-module `vx_rr_picker` (NUM_REQS): combinational cyclic priority pick.
  - Inputs: valid vector and rr_ptr.
  - Outputs: one-hot grant and the winner index.
  - Also usable by other issue-slot schedulers.
- The top level holds the FSM, owner, rr_ptr, the output register and the error flag.

## Test plan
- Single-beat fairness: NUM_REQS=4, all valid, sop=eop=1 every cycle for 8 cycles → wb_idx sequence is 0,1,2,3,0,1,2,3 starting one cycle after the first valid; wb_valid=1 continuously.
- Packet lock: req1 sends 3 beats (sop,–,eop) while req0, req2 and req3 are held valid → wb_idx=1,1,1 contiguous; req_ready[0,2,3]=0 during the lock; the next grant goes to req2.
- Owner bubble: req1 locked, req1 drops valid for 2 cycles while req0 is valid → wb_valid=0 for 2 cycles and req_ready[0] stays 0; after req1 sends its eop, req0 is not served before req2/req3 if they are valid.
- Protocol error: req0 sends sop=0,eop=1 in IDLE → beat forwarded, proto_err=1 the next cycle and held until reset.
- Reset mid-packet: req2 locked after its sop beat, assert reset 1 cycle, then req2 and req0 both valid with sop=eop=1 → req0 granted first (rr_ptr=0); all outputs are 0 in the cycle after reset.
- Wrap: NUM_REQS=4, req3 sends eop, then req0 and req3 valid → req0 granted.

Source files
------------

// File: rtl/vx_wb_commit_arbiter_pkg.sv
// Shared types for the issue-slot writeback commit path.
// Used by the commit arbiter and the writeback packers.
package vx_wb_commit_arbiter_pkg;

    localparam int WB_DATAW = 64;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [WB_DATAW-1:0] data;
        logic                sop;
        logic                eop;
    } wb_beat_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_wb_commit_arbiter_if.sv
// Request and writeback bundle between execute units and the scoreboard.
// master = requester side, slave = arbiter side.
interface vx_wb_commit_arbiter_if
    import vx_wb_commit_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = WB_DATAW
);
    localparam int IDXW = idx_width(NUM_REQS);

    logic [NUM_REQS-1:0]            req_valid;
    logic [NUM_REQS-1:0][DATAW-1:0] req_data;
    logic [NUM_REQS-1:0]            req_sop;
    logic [NUM_REQS-1:0]            req_eop;
    logic [NUM_REQS-1:0]            req_ready;

    logic             wb_valid;
    logic [DATAW-1:0] wb_data;
    logic             wb_sop;
    logic             wb_eop;
    logic [IDXW-1:0]  wb_idx;
    logic             proto_err;

    modport master (
        output req_valid, req_data, req_sop, req_eop,
        input  req_ready,
        input  wb_valid, wb_data, wb_sop, wb_eop, wb_idx, proto_err
    );

    modport slave (
        input  req_valid, req_data, req_sop, req_eop,
        output req_ready,
        output wb_valid, wb_data, wb_sop, wb_eop, wb_idx, proto_err
    );

endinterface

// File: rtl/vx_wb_commit_arbiter_rr_picker.sv
// Combinational cyclic priority pick: first valid at or after i_ptr.
// Reusable by other issue-slot schedulers.
module vx_rr_picker
    import vx_wb_commit_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    localparam int IDXW    = idx_width(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] i_valid,
    input  logic [IDXW-1:0]     i_ptr,
    output logic [NUM_REQS-1:0] o_grant,
    output logic [IDXW-1:0]     o_idx,
    output logic                o_any
);

    logic [IDXW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            w_cand = IDXW'((int'(i_ptr) + k) % NUM_REQS);
            if (!o_any && i_valid[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/vx_wb_commit_arbiter.sv
// Round-robin writeback arbiter with sop..eop packet locking and a
// registered, non-backpressured output toward the scoreboard.
module vx_wb_commit_arbiter
    import vx_wb_commit_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = WB_DATAW
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_wb_commit_arbiter_if.slave bus
);

    localparam int IDXW = idx_width(NUM_REQS);

    arb_state_e      r_state;
    logic [IDXW-1:0] r_rr_ptr;
    logic [IDXW-1:0] r_owner;
    logic            r_wb_valid;
    wb_beat_t        r_beat;
    logic [IDXW-1:0] r_wb_idx;
    logic            r_proto_err;

    logic [NUM_REQS-1:0] w_pick_gnt;
    logic [IDXW-1:0]     w_pick_idx;
    logic                w_pick_any;
    logic [NUM_REQS-1:0] w_gnt;
    logic [IDXW-1:0]     w_idx;
    logic                w_any;
    logic                w_sop;
    logic                w_eop;
    logic [IDXW-1:0]     w_next;

    vx_rr_picker #(
        .NUM_REQS (NUM_REQS)
    ) u_picker (
        .i_valid (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // While locked only the owner may win; an idle owner is a bubble.
    always_comb begin
        w_gnt = '0;
        w_idx = r_owner;
        w_any = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_gnt = w_pick_gnt;
                w_idx = w_pick_idx;
                w_any = w_pick_any;
            end
            ST_LOCKED: begin
                w_any          = bus.req_valid[r_owner];
                w_gnt[r_owner] = w_any;
            end
            default: begin
                w_gnt = '0;
            end
        endcase
    end

    assign w_sop  = bus.req_sop[w_idx];
    assign w_eop  = bus.req_eop[w_idx];
    assign w_next = (w_idx == IDXW'(NUM_REQS - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_wb_valid  <= 1'b0;
            r_beat      <= '0;
            r_wb_idx    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_wb_valid <= w_any;
            if (w_any) begin
                r_beat.data <= WB_DATAW'(bus.req_data[w_idx]);
                r_beat.sop  <= w_sop;
                r_beat.eop  <= w_eop;
                r_wb_idx    <= w_idx;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        if (!w_sop) r_proto_err <= 1'b1;
                        if (w_eop) begin
                            r_rr_ptr <= w_next;
                        end else begin
                            r_state <= ST_LOCKED;
                            r_owner <= w_idx;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_any) begin
                        if (w_sop) r_proto_err <= 1'b1;
                        if (w_eop) begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= w_next;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.wb_valid  = r_wb_valid;
    assign bus.wb_data   = DATAW'(r_beat.data);
    assign bus.wb_sop    = r_beat.sop;
    assign bus.wb_eop    = r_beat.eop;
    assign bus.wb_idx    = r_wb_idx;
    assign bus.proto_err = r_proto_err;

endmodule
